// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file debug dump reader: FSM state
// encoding and the default register-file geometry.
package regfile_dbg_pkg;

    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Bundle of the dump reader's control, register-file read port and output
// stream. The reader drives through the master modport; the register file
// plus consumer side (harness or debug logic) uses the slave modport.
interface regfile_dump_reader_if
    import regfile_dbg_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) ();

    logic                     start;
    logic                     abort;
    logic [ADDRESS_WIDTH-1:0] start_addr;
    logic [ADDRESS_WIDTH-1:0] end_addr;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     dump_valid;
    logic                     dump_ready;
    logic [DATA_WIDTH-1:0]    dump_data;
    logic [ADDRESS_WIDTH-1:0] dump_addr;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, abort, start_addr, end_addr, rd_data, dump_ready,
        output rd_addr, dump_valid, dump_data, dump_addr, busy, done
    );

    modport slave (
        output start, abort, start_addr, end_addr, rd_data, dump_ready,
        input  rd_addr, dump_valid, dump_data, dump_addr, busy, done
    );

endinterface

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks an inclusive, wrapping address range through
// one asynchronous register-file read port and streams each word out on a
// valid/ready interface. A single holding register keeps the word stable
// while the consumer applies backpressure.
module regfile_dump_reader
    import regfile_dbg_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    regfile_dump_reader_if.master bus
);

    dump_state_t state;
    dump_state_t next_state;

    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [ADDRESS_WIDTH-1:0] end_latched;
    logic [ADDRESS_WIDTH-1:0] dump_addr_q;
    logic [DATA_WIDTH-1:0]    dump_data_q;
    logic                     last_word;

    // The range is inclusive, so the walk ends when the address just
    // handed over equals the latched end; wrap comes free from the modulo add.
    assign last_word = (cur_addr == end_latched);

    // State register; reset drops any dump in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort wins over a handshake in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = READ;
                end
            end
            READ: begin
                next_state = bus.abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (bus.abort) begin
                    next_state = IDLE;
                end else if (bus.dump_ready) begin
                    next_state = last_word ? DONE : READ;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Address counter, range latch and output holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr    <= '0;
            end_latched <= '0;
            dump_data_q <= '0;
            dump_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cur_addr    <= bus.start_addr;
                        end_latched <= bus.end_addr;
                    end
                end
                READ: begin
                    if (!bus.abort) begin
                        dump_data_q <= bus.rd_data;
                        dump_addr_q <= cur_addr;
                    end
                end
                HOLD: begin
                    if (!bus.abort && bus.dump_ready && !last_word) begin
                        cur_addr <= cur_addr + ADDRESS_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status and read-port outputs decode straight from the state so that
    // an asynchronous reset clears them without waiting for a clock edge.
    always_comb begin
        bus.rd_addr    = '0;
        bus.dump_valid = 1'b0;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state)
            READ: begin
                bus.rd_addr = cur_addr;
                bus.busy    = 1'b1;
            end
            HOLD: begin
                bus.dump_valid = 1'b1;
                bus.busy       = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
                bus.busy = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.dump_data = dump_data_q;
    assign bus.dump_addr = dump_addr_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: a behavioural register file,
// a table of dump ranges, randomized dumps and hand-written corner cases.
module tb_regfile_dump_reader;
    import regfile_dbg_pkg::*;

    localparam int NREGS  = 32;
    localparam int BUDGET = 1000;

    typedef struct {
        int sa;
        int ea;
        int ready_mode;
        int exp_words;
    } vec_t;

    logic clk;
    logic rst;

    regfile_dump_reader_if bus ();

    regfile_dump_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] regs     [NREGS];
    logic [31:0] exp_regs [NREGS];

    assign bus.rd_data = regs[bus.rd_addr];

    int compared;
    int mismatched;

    logic [4:0]  got_addr[$];
    logic [31:0] got_data[$];
    int          done_cycle;
    int          done_count;

    vec_t vecs[5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sa, input int ea);
        for (int i = 0; i < NREGS; i++) exp_regs[i] = regs[i];
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = 5'(sa);
        bus.end_addr   = 5'(ea);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < NREGS; i++) regs[i] = 32'hA000_0000 + 32'(i);
    endtask

    // Drives dump_ready per mode, records every handshake, checks that a
    // stalled word stays put, and stops after the done pulse.
    task automatic collectDump(input int ready_mode, input bit poke_start, input bit do_write);
        bit          prev_stall;
        bit          finished;
        logic [4:0]  prev_addr;
        logic [31:0] prev_data;
        got_addr.delete();
        got_data.delete();
        done_cycle = -1;
        done_count = 0;
        prev_stall = 1'b0;
        finished   = 1'b0;
        prev_addr  = '0;
        prev_data  = '0;
        for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
            @(negedge clk);
            case (ready_mode)
                0:       bus.dump_ready = 1'b1;
                1:       bus.dump_ready = (cyc % 3 == 0);
                default: bus.dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke_start) begin
                bus.start      = (cyc == 2);
                bus.start_addr = 5'd0;
                bus.end_addr   = 5'd31;
            end
            if (do_write && cyc == 10) begin
                regs[20] = 32'h1234_5678;
                regs[3]  = 32'hFFFF_FFFF;
            end
            if (prev_stall) begin
                checkOutput("valid held under stall", bus.dump_valid, 1);
                checkOutput("addr held under stall", bus.dump_addr, prev_addr);
                checkOutput("data held under stall", bus.dump_data, prev_data);
            end
            if (bus.dump_valid && bus.dump_ready) begin
                got_addr.push_back(bus.dump_addr);
                got_data.push_back(bus.dump_data);
            end
            prev_stall = bus.dump_valid && !bus.dump_ready;
            prev_addr  = bus.dump_addr;
            prev_data  = bus.dump_data;
            if (bus.done) begin
                done_count++;
                done_cycle = cyc;
                finished   = 1'b1;
            end
        end
        bus.start = 1'b0;
        if (!finished) begin
            checkOutput("done within budget", 0, 1);
        end else begin
            @(negedge clk);
            checkOutput("done single cycle", bus.done, 0);
            checkOutput("idle after done", bus.busy, 0);
        end
        bus.dump_ready = 1'b0;
    endtask

    // Reference: the dump is every address from sa stepping up modulo 32
    // until ea inclusive, each carrying the register value in exp_regs.
    task automatic checkDump(input int sa, input int ea, input int exp_words);
        int n;
        int a;
        n = ((ea - sa + NREGS) % NREGS) + 1;
        checkOutput("word count", got_addr.size(), exp_words);
        checkOutput("model word count", got_addr.size(), n);
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            a = (sa + i) % NREGS;
            checkOutput($sformatf("addr of word %0d", i), got_addr[i], a);
            checkOutput($sformatf("data of word %0d", i), got_data[i], exp_regs[a]);
        end
        checkOutput("done pulses", done_count, 1);
    endtask

    initial begin
        int  handshakes;
        bit  found;
        int  done_seen;
        int  sa;
        int  ea;

        compared       = 0;
        mismatched     = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        bus.dump_ready = 1'b0;
        preload_ramp();

        vecs[0] = '{sa: 0,  ea: 31, ready_mode: 0, exp_words: 32};
        vecs[1] = '{sa: 30, ea: 1,  ready_mode: 1, exp_words: 4};
        vecs[2] = '{sa: 31, ea: 0,  ready_mode: 2, exp_words: 2};
        vecs[3] = '{sa: 5,  ea: 4,  ready_mode: 0, exp_words: 32};
        vecs[4] = '{sa: 17, ea: 17, ready_mode: 1, exp_words: 1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset dump_valid", bus.dump_valid, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset done", bus.done, 0);
        checkOutput("reset rd_addr", bus.rd_addr, 0);
        checkOutput("reset dump_addr", bus.dump_addr, 0);
        checkOutput("reset dump_data", bus.dump_data, 0);

        // Table-driven ranges
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].sa, vecs[v].ea);
            collectDump(vecs[v].ready_mode, 1'b0, 1'b0);
            checkDump(vecs[v].sa, vecs[v].ea, vecs[v].exp_words);
            if (vecs[v].ready_mode == 0)
                checkOutput("done latency", done_cycle, 2 * vecs[v].exp_words + 1);
        end

        // Single word, start re-pulsed while busy
        regs[10] = 32'hDEAD_BEEF;
        applyStimulus(10, 10);
        collectDump(0, 1'b1, 1'b0);
        checkDump(10, 10, 1);
        checkOutput("single word latency", done_cycle, 3);
        if (got_data.size() > 0) checkOutput("single word data", got_data[0], 32'hDEAD_BEEF);

        // Abort in HOLD of word 5 with a same-cycle ready
        preload_ramp();
        applyStimulus(0, 31);
        bus.dump_ready = 1'b1;
        handshakes = 0;
        found      = 1'b0;
        for (int cyc = 1; cyc <= 200 && !found; cyc++) begin
            @(negedge clk);
            if (bus.dump_valid && bus.dump_addr == 5'd5) begin
                bus.abort = 1'b1;
                found     = 1'b1;
            end else if (bus.dump_valid) begin
                handshakes++;
            end
        end
        checkOutput("abort reached word 5", found, 1);
        checkOutput("words before abort", handshakes, 5);
        @(negedge clk);
        bus.abort      = 1'b0;
        bus.dump_ready = 1'b0;
        checkOutput("valid after abort", bus.dump_valid, 0);
        checkOutput("busy after abort", bus.busy, 0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        checkOutput("no done after abort", done_seen, 0);
        applyStimulus(7, 9);
        collectDump(0, 1'b0, 1'b0);
        checkDump(7, 9, 3);

        // Asynchronous reset in the middle of a dump
        applyStimulus(12, 20);
        @(negedge clk);
        checkOutput("rd_addr in READ", bus.rd_addr, 12);
        @(negedge clk);
        checkOutput("valid before reset", bus.dump_valid, 1);
        checkOutput("dump_addr before reset", bus.dump_addr, 12);
        #1 rst = 1'b1;
        #1;
        checkOutput("async reset dump_valid", bus.dump_valid, 0);
        checkOutput("async reset busy", bus.busy, 0);
        checkOutput("async reset done", bus.done, 0);
        checkOutput("async reset rd_addr", bus.rd_addr, 0);
        checkOutput("async reset dump_addr", bus.dump_addr, 0);
        checkOutput("async reset dump_data", bus.dump_data, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2, 3);
        collectDump(0, 1'b0, 1'b0);
        checkDump(2, 3, 2);

        // Register writes during a dump
        preload_ramp();
        applyStimulus(0, 31);
        collectDump(0, 1'b0, 1'b1);
        exp_regs[20] = 32'h1234_5678;
        checkDump(0, 31, 32);

        // Randomized ranges, contents and backpressure
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
            sa = $urandom_range(0, NREGS - 1);
            ea = $urandom_range(0, NREGS - 1);
            applyStimulus(sa, ea);
            collectDump(2, 1'b0, 1'b0);
            checkDump(sa, ea, ((ea - sa + NREGS) % NREGS) + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
